// File: rtl/video_crtc_prog.sv
// video_crtc_prog: programmable text-mode CRTC.
// Generates raster counters, the character address, the row/dot indices,
// the syncs, blanking and a blinking hardware cursor. All timing comes from
// a register file with a pending copy and an active copy. The active copy is
// loaded from the pending copy on the frame-wrap cycle, so a mode change
// never tears a frame.
//
// Ports:
//   iClk25       pixel clock, the only clock
//   iRst         synchronous active-high reset
//   iRegWr       register write strobe (writes the pending copy)
//   iRegIdx      register index 0-13; 14-15 are ignored
//   iRegData     write data, LSB-aligned, excess bits ignored
//   oAddr        character address of the current dot
//   oRA          raster row inside the character cell
//   oDA          dot index inside the character (0-7, or 0-15 with xdouble)
//   oHs, oVs     syncs; the level is (active XNOR polarity bit)
//   oBlank       high outside the visible area
//   oCursor      high while the cursor covers this dot
//   oFrameStart  high on the first dot of the frame (x=0, y=0)
module video_crtc_prog #(
   parameter int ADDR_W = 14,
   parameter int ROW_W  = 4,
   parameter int CNT_W  = 10
) (
   input  logic              iClk25,
   input  logic              iRst,
   input  logic              iRegWr,
   input  logic [3:0]        iRegIdx,
   input  logic [15:0]       iRegData,
   output logic [ADDR_W-1:0] oAddr,
   output logic [ROW_W-1:0]  oRA,
   output logic [3:0]        oDA,
   output logic              oHs,
   output logic              oVs,
   output logic              oBlank,
   output logic              oCursor,
   output logic              oFrameStart
);

   typedef struct packed {
      logic [CNT_W-1:0]  h_vis;
      logic [CNT_W-1:0]  h_sync_s;
      logic [CNT_W-1:0]  h_sync_e;
      logic [CNT_W-1:0]  h_total;
      logic [CNT_W-1:0]  v_vis;
      logic [CNT_W-1:0]  v_sync_s;
      logic [CNT_W-1:0]  v_sync_e;
      logic [CNT_W-1:0]  v_total;
      logic [ROW_W-1:0]  max_ra;
      logic [ADDR_W-1:0] stride;
      logic [ADDR_W-1:0] start_addr;
      logic [ADDR_W-1:0] cursor_addr;
      logic [ROW_W-1:0]  cur_start;
      logic [ROW_W-1:0]  cur_end;
      logic [4:0]        ctrl;   // {ydouble, xdouble, cursor_en, vs_pol, hs_pol}
   } regs_t;

   function automatic regs_t reset_regs();
      regs_t r;
      r.h_vis       = CNT_W'(639);
      r.h_sync_s    = CNT_W'(656);
      r.h_sync_e    = CNT_W'(752);
      r.h_total     = CNT_W'(799);
      r.v_vis       = CNT_W'(399);
      r.v_sync_s    = CNT_W'(412);
      r.v_sync_e    = CNT_W'(414);
      r.v_total     = CNT_W'(448);
      r.max_ra      = ROW_W'(7);
      r.stride      = ADDR_W'(80);
      r.start_addr  = '0;
      r.cursor_addr = '0;
      r.cur_start   = ROW_W'(6);
      r.cur_end     = ROW_W'(7);
      r.ctrl        = 5'h10;
      return r;
   endfunction

   regs_t             pend_q, pend_d;
   regs_t             act_q, act_d;
   logic [CNT_W-1:0]  x_q, x_d;
   logic [CNT_W-1:0]  y_q, y_d;
   logic [ROW_W-1:0]  ra_q, ra_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [4:0]        blink_q, blink_d;

   logic eol;
   logic wrap;

   // Only part of the write data reaches any register.
   wire unused_ok = &{1'b0, iRegData};

   always_comb begin
      pend_d     = pend_q;
      act_d      = act_q;
      x_d        = x_q + CNT_W'(1);
      y_d        = y_q;
      ra_d       = ra_q;
      row_base_d = row_base_q;
      blink_d    = blink_q;

      eol  = (x_q == act_q.h_total);
      wrap = eol && (y_q == act_q.v_total);

      // The copy below uses pend_q, so a write on the wrap cycle is only
      // activated at the following wrap.
      if (iRegWr) begin
         case (iRegIdx)
            4'd0:  pend_d.h_vis       = CNT_W'(iRegData);
            4'd1:  pend_d.h_sync_s    = CNT_W'(iRegData);
            4'd2:  pend_d.h_sync_e    = CNT_W'(iRegData);
            4'd3:  pend_d.h_total     = CNT_W'(iRegData);
            4'd4:  pend_d.v_vis       = CNT_W'(iRegData);
            4'd5:  pend_d.v_sync_s    = CNT_W'(iRegData);
            4'd6:  pend_d.v_sync_e    = CNT_W'(iRegData);
            4'd7:  pend_d.v_total     = CNT_W'(iRegData);
            4'd8:  pend_d.max_ra      = ROW_W'(iRegData);
            4'd9:  pend_d.stride      = ADDR_W'(iRegData);
            4'd10: pend_d.start_addr  = ADDR_W'(iRegData);
            4'd11: pend_d.cursor_addr = ADDR_W'(iRegData);
            4'd12: begin
               pend_d.cur_start = ROW_W'(iRegData);
               pend_d.cur_end   = ROW_W'(iRegData[15:8]);
            end
            4'd13: pend_d.ctrl        = iRegData[4:0];
            default: ;
         endcase
      end

      if (eol) begin
         x_d = '0;
         y_d = y_q + CNT_W'(1);
      end

      if (wrap) begin
         y_d        = '0;
         act_d      = pend_q;
         blink_d    = blink_q + 5'd1;
         // Row base restarts from the value being activated this cycle.
         ra_d       = '0;
         row_base_d = pend_q.start_addr;
      end else if (eol && (!act_q.ctrl[4] || y_q[0])) begin
         // With ydouble every character row spans two scan lines.
         if (ra_q == act_q.max_ra) begin
            ra_d       = '0;
            row_base_d = row_base_q + act_q.stride;
         end else begin
            ra_d = ra_q + ROW_W'(1);
         end
      end
   end

   always_ff @(posedge iClk25) begin
      if (iRst) begin
         pend_q     <= reset_regs();
         act_q      <= reset_regs();
         x_q        <= '0;
         y_q        <= '0;
         ra_q       <= '0;
         row_base_q <= '0;
         blink_q    <= '0;
      end else begin
         pend_q     <= pend_d;
         act_q      <= act_d;
         x_q        <= x_d;
         y_q        <= y_d;
         ra_q       <= ra_d;
         row_base_q <= row_base_d;
         blink_q    <= blink_d;
      end
   end

   // Everything below depends only on registered state.
   logic [CNT_W-1:0] col;
   logic             hs_act;
   logic             vs_act;

   always_comb begin
      col         = act_q.ctrl[3] ? (x_q >> 4) : (x_q >> 3);
      oDA         = act_q.ctrl[3] ? x_q[3:0] : {1'b0, x_q[2:0]};
      oAddr       = row_base_q + ADDR_W'(col);
      oRA         = ra_q;
      oBlank      = (x_q > act_q.h_vis) || (y_q > act_q.v_vis);
      hs_act      = (x_q >= act_q.h_sync_s) && (x_q < act_q.h_sync_e);
      vs_act      = (y_q >= act_q.v_sync_s) && (y_q < act_q.v_sync_e);
      oHs         = ~(hs_act ^ act_q.ctrl[0]);
      oVs         = ~(vs_act ^ act_q.ctrl[1]);
      oFrameStart = (x_q == '0) && (y_q == '0);
      oCursor     = act_q.ctrl[2] && blink_q[4] && !oBlank &&
                    (oAddr == act_q.cursor_addr) &&
                    (ra_q >= act_q.cur_start) && (ra_q <= act_q.cur_end);
   end

endmodule

// File: tb/tb_video_crtc_prog.sv
// Bench for video_crtc_prog: directed steps plus random register traffic,
// checked every cycle against a frame-level arithmetic model of the raster.
module tb_video_crtc_prog;

   localparam int LIMIT = 400000;

   logic        iClk25 = 1'b0;
   logic        iRst;
   logic        iRegWr;
   logic [3:0]  iRegIdx;
   logic [15:0] iRegData;
   logic [13:0] oAddr;
   logic [3:0]  oRA;
   logic [3:0]  oDA;
   logic        oHs, oVs, oBlank, oCursor, oFrameStart;

   always #20 iClk25 = ~iClk25;

   video_crtc_prog dut (
      .iClk25(iClk25), .iRst(iRst), .iRegWr(iRegWr), .iRegIdx(iRegIdx),
      .iRegData(iRegData), .oAddr(oAddr), .oRA(oRA), .oDA(oDA), .oHs(oHs),
      .oVs(oVs), .oBlank(oBlank), .oCursor(oCursor), .oFrameStart(oFrameStart)
   );

   int n_assert = 0;
   int fail_cnt = 0;

   // Reference model: raster position, register copies, frames since reset.
   int act[14];
   int pend[14];
   int mx, my, fc;
   bit model_valid = 0;

   // Frame bookkeeping from observed outputs.
   int cyc = 0, last_fs_cyc = 0, period = 0, cur_acc = 0, frame_cur = 0;
   bit obs_fs = 0, obs_cur = 0;

   function automatic int rst_val(int i);
      case (i)
         0: return 639;  1: return 656;  2: return 752;  3: return 799;
         4: return 399;  5: return 412;  6: return 414;  7: return 448;
         8: return 7;    9: return 80;   10: return 0;   11: return 0;
         12: return 'h0607;
         default: return 'h10;
      endcase
   endfunction

   function automatic int reg_mask(int i);
      if (i < 8) return 'h3FF;
      case (i)
         8: return 'hF;
         12: return 'h0F0F;
         13: return 'h1F;
         default: return 'h3FFF;
      endcase
   endfunction

   function automatic logic [26:0] expect_vec();
      int ctrl, ph, ra, row, col, da, addr, cs, ce;
      bit xd, yd, blank, hs, vs, cur, fs;
      logic [13:0] a;
      logic [3:0] r, d;
      ctrl = act[13];
      xd = ctrl[3];
      yd = ctrl[4];
      da  = xd ? mx % 16 : mx % 8;
      col = xd ? mx / 16 : mx / 8;
      ph  = yd ? my / 2 : my;
      ra  = ph % (act[8] + 1);
      row = ph / (act[8] + 1);
      addr = (act[10] + row * act[9] + col) % 16384;
      blank = (mx > act[0]) || (my > act[4]);
      hs = (mx >= act[1] && mx < act[2]) ? ctrl[0] : !ctrl[0];
      vs = (my >= act[5] && my < act[6]) ? ctrl[1] : !ctrl[1];
      cs = act[12] & 15;
      ce = (act[12] >> 8) & 15;
      cur = ctrl[2] && (fc >= 16) && !blank && (addr == act[11]) &&
            (cs <= ra) && (ra <= ce);
      fs = (mx == 0) && (my == 0);
      a = addr[13:0];
      r = ra[3:0];
      d = da[3:0];
      return {a, r, d, hs, vs, blank, cur, fs};
   endfunction

   task automatic model_step(input logic rst, input logic wr,
                             input logic [3:0] idx, input logic [15:0] data);
      bit wrap;
      if (rst) begin
         for (int i = 0; i < 14; i++) begin
            act[i] = rst_val(i);
            pend[i] = rst_val(i);
         end
         mx = 0; my = 0; fc = 0;
         model_valid = 1;
      end else begin
         wrap = (mx == act[3]) && (my == act[7]);
         if (mx == act[3]) begin
            mx = 0;
            my = wrap ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
         if (wrap) begin
            act = pend;
            fc = (fc + 1) % 32;
         end
         if (wr && idx < 14) pend[idx] = int'(data) & reg_mask(int'(idx));
      end
   endtask

   task automatic tick(input logic rst, input logic wr,
                       input logic [3:0] idx, input logic [15:0] data);
      logic [26:0] obs, exp;
      iRst = rst; iRegWr = wr; iRegIdx = idx; iRegData = data;
      #1;
      if (model_valid) begin
         if (fail_cnt < 40) begin
            obs = {oAddr, oRA, oDA, oHs, oVs, oBlank, oCursor, oFrameStart};
            exp = expect_vec();
            n_assert++;
            assert (obs === exp) else begin
               fail_cnt++;
               $error("FAIL model x=%0d y=%0d observed=%h expected=%h", mx, my, obs, exp);
            end
         end
         obs_fs = oFrameStart;
         obs_cur = oCursor;
         if (obs_fs) begin
            period = cyc - last_fs_cyc;
            last_fs_cyc = cyc;
            frame_cur = cur_acc;
            cur_acc = int'(obs_cur);
         end else begin
            cur_acc += int'(obs_cur);
         end
      end
      cyc++;
      @(posedge iClk25);
      model_step(rst, wr, idx, data);
      @(negedge iClk25);
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 4'd0, 16'd0);
   endtask

   task automatic wr_reg(input int idx, input int data);
      tick(1'b0, 1'b1, idx[3:0], data[15:0]);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_xy(input int x, input int y);
      int g = 0;
      while (!(mx == x && my == y) && g < LIMIT) begin
         idle();
         g++;
      end
      n_assert++;
      assert (g < LIMIT) else begin
         fail_cnt++;
         $error("FAIL timeout_xy observed=%0d expected=%0d", g, x + 1000 * y);
      end
   endtask

   task automatic wait_fs();
      int g = 0;
      idle();
      while (!obs_fs && g < LIMIT) begin
         idle();
         g++;
      end
      n_assert++;
      assert (g < LIMIT) else begin
         fail_cnt++;
         $error("FAIL timeout_fs observed=%0d expected<%0d", g, LIMIT);
      end
   endtask

   int small_cfg[14] = '{29, 31, 35, 39, 15, 16, 18, 19, 7, 80, 'h3FF0, 0, 'h0607, 'h10};
   int cur_cfg[14]   = '{47, 48, 48, 47, 15, 0, 0, 15, 7, 80, 0, 5, 'h0706, 'h14};

   initial begin
      int idx, data, n, exp_cur;

      iRst = 1'b1; iRegWr = 1'b0; iRegIdx = '0; iRegData = '0;
      @(negedge iClk25);
      tick(1'b1, 1'b1, 4'd3, 16'd5);
      tick(1'b1, 1'b0, 4'd0, 16'd0);
      iRst = 1'b0;

      // First cycle after reset.
      chk("rst_fs", int'(oFrameStart), 1);
      chk("rst_blank", int'(oBlank), 0);
      chk("rst_addr", int'(oAddr), 0);
      chk("rst_da", int'(oDA), 0);
      chk("rst_ra", int'(oRA), 0);
      chk("rst_cursor", int'(oCursor), 0);
      chk("rst_hs", int'(oHs), 1);
      chk("rst_vs", int'(oVs), 1);

      // Stage a small mode while the default frame runs on.
      for (int i = 0; i < 14; i++) wr_reg(i, small_cfg[i]);
      wr_reg(14, 'hFFFF);
      wr_reg(15, 'h1234);

      wait_xy(639, 0); chk("blank_x639", int'(oBlank), 0);
      wait_xy(640, 0); chk("blank_x640", int'(oBlank), 1);
      wait_xy(655, 0); chk("hs_x655", int'(oHs), 1);
      wait_xy(656, 0); chk("hs_x656", int'(oHs), 0);
      wait_xy(751, 0); chk("hs_x751", int'(oHs), 0);
      wait_xy(752, 0); chk("hs_x752", int'(oHs), 1);
      wait_xy(0, 399); chk("blank_y399", int'(oBlank), 0);
      wait_xy(0, 400); chk("blank_y400", int'(oBlank), 1);
      wait_xy(0, 411); chk("vs_y411", int'(oVs), 1);
      wait_xy(0, 412); chk("vs_y412", int'(oVs), 0);
      wait_xy(0, 413); chk("vs_y413", int'(oVs), 0);
      wait_xy(0, 414); chk("vs_y414", int'(oVs), 1);

      wait_fs(); chk("period_default", period, 359200);
      wait_fs(); chk("period_small", period, 800);

      // Addressing with a wrapping start address and ydouble.
      wait_xy(0, 2);  chk("ra_y2", int'(oRA), 1);
      wait_xy(8, 16); chk("addr_y16_x8", int'(oAddr), 'h0041);
      chk("ra_y16", int'(oRA), 0);

      // Write on the exact wrap cycle.
      wait_xy(39, 19);
      wr_reg(3, 49);
      wait_fs(); chk("period_wrap_frame", period, 800);
      wait_fs(); chk("period_after_wrap_write", period, 800);
      wait_fs(); chk("period_htotal49", period, 1000);

      // xdouble.
      wr_reg(13, 'h18);
      wait_fs();
      wait_xy(15, 0); chk("xd_da15", int'(oDA), 15); chk("xd_addr15", int'(oAddr), 'h3FF0);
      wait_xy(16, 0); chk("xd_da16", int'(oDA), 0);  chk("xd_addr16", int'(oAddr), 'h3FF1);
      wait_xy(32, 0); chk("xd_addr32", int'(oAddr), 'h3FF2);

      // Random register traffic.
      for (int i = 0; i < 200; i++) begin
         idx = $urandom_range(0, 15);
         case (idx)
            3: data = $urandom_range(20, 60);
            7: data = $urandom_range(10, 40);
            0, 1, 2: data = $urandom_range(0, 70);
            4, 5, 6: data = $urandom_range(0, 45);
            8: data = $urandom_range(0, 15);
            9: data = $urandom_range(0, 200);
            13: data = $urandom_range(0, 31);
            default: data = $urandom_range(0, 65535);
         endcase
         wr_reg(idx, data);
         n = $urandom_range(0, 60);
         for (int k = 0; k < n; k++) idle();
      end

      // Cursor blink over 32 frames.
      for (int i = 0; i < 14; i++) wr_reg(i, cur_cfg[i]);
      wait_fs();
      for (int f = 0; f < 32; f++) begin
         wait_fs();
         exp_cur = (((fc + 31) % 32) >= 16) ? 32 : 0;
         chk("cursor_period", period, 768);
         chk("cursor_dots", frame_cur, exp_cur);
      end

      // Start row above end row: no cursor at all.
      wr_reg(12, 'h0208);
      wait_fs();
      for (int f = 0; f < 17; f++) begin
         wait_fs();
         chk("cursor_off_dots", frame_cur, 0);
      end

      // Active-high syncs.
      wr_reg(1, 40); wr_reg(2, 44); wr_reg(5, 4); wr_reg(6, 6); wr_reg(13, 'h13);
      wait_fs();
      chk("pol_hs_idle", int'(oHs), 0);
      chk("pol_vs_idle", int'(oVs), 0);
      wait_xy(40, 0); chk("pol_hs_on", int'(oHs), 1);
      wait_xy(44, 0); chk("pol_hs_off", int'(oHs), 0);
      wait_xy(0, 4);  chk("pol_vs_on", int'(oVs), 1);
      wait_xy(0, 6);  chk("pol_vs_off", int'(oVs), 0);

      // Reset mid-frame with a simultaneous write.
      wait_xy(0, 10);
      tick(1'b1, 1'b1, 4'd3, 16'd9);
      chk("mrst_fs", int'(oFrameStart), 1);
      chk("mrst_hs", int'(oHs), 1);
      chk("mrst_vs", int'(oVs), 1);
      chk("mrst_blank", int'(oBlank), 0);
      chk("mrst_addr", int'(oAddr), 0);
      chk("mrst_da", int'(oDA), 0);
      wait_xy(640, 0); chk("mrst_blank_x640", int'(oBlank), 1);
      wait_xy(656, 0); chk("mrst_hs_x656", int'(oHs), 0);
      wait_xy(20, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fail_cnt);
      $finish;
   end

endmodule
